// File: rtl/addsub_pipe_if.sv
// Operation/result bundle for addsub_pipe: request fields in, per-lane results,
// flags and status out.
interface addsub_pipe_if #(
  parameter int W     = 10,
  parameter int LANES = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic                 start;
  logic [1:0]           op;
  logic [LANES*W-1:0]   a;
  logic [LANES*W-1:0]   b;
  logic [TAG_W-1:0]     tag_in;
  logic [LANES*W-1:0]   y;
  logic [LANES-1:0]     ovf;
  logic [TAG_W-1:0]     tag_out;
  logic                 valid;
  logic                 busy;
  logic [CNT_W-1:0]     done_cnt;

  modport master (
    output start, op, a, b, tag_in,
    input  y, ovf, tag_out, valid, busy, done_cnt
  );

  modport slave (
    input  start, op, a, b, tag_in,
    output y, ovf, tag_out, valid, busy, done_cnt
  );
endinterface

// File: rtl/addsub_pipe.sv
// Multi-lane pipelined add/subtract (wrap or saturate) with fixed latency,
// tag pass-through, busy flag and saturating completion counter.
module addsub_pipe #(
  parameter int W      = 10,
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  addsub_pipe_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {carry/borrow, result}; bit W of the W+1-bit difference is the borrow.
  function automatic logic [W:0] lane_calc(
    input logic [1:0]   mode,
    input logic [W-1:0] x,
    input logic [W-1:0] z
  );
    logic [W:0]   t;
    logic [W-1:0] res;
    t   = mode[0] ? ({1'b0, x} - {1'b0, z}) : ({1'b0, x} + {1'b0, z});
    res = (mode[1] && t[W]) ? (mode[0] ? {W{1'b0}} : {W{1'b1}}) : t[W-1:0];
    return {t[W], res};
  endfunction

  logic [LANES*W-1:0]               w_y;
  logic [LANES-1:0]                 w_ovf;
  logic [STAGES-1:0]                w_ld;
  logic [STAGES-1:0][LANES*W-1:0]   w_din_y;
  logic [STAGES-1:0][LANES-1:0]     w_din_ovf;
  logic [STAGES-1:0][TAG_W-1:0]     w_din_tag;

  logic [STAGES-1:0]                r_vld;
  logic [STAGES-1:0][LANES*W-1:0]   r_y;
  logic [STAGES-1:0][LANES-1:0]     r_ovf;
  logic [STAGES-1:0][TAG_W-1:0]     r_tag;
  logic                             r_busy;
  logic [CNT_W-1:0]                 r_cnt;

  // Per-lane arithmetic on the incoming operands
  always_comb begin
    w_y   = {(LANES*W){1'b0}};
    w_ovf = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      {w_ovf[i], w_y[i*W +: W]} = lane_calc(bus.op, bus.a[i*W +: W], bus.b[i*W +: W]);
    end
  end

  // Load enables and data inputs for each stage: stage 1 from the ports, others from predecessor
  always_comb begin
    w_ld         = {STAGES{1'b0}};
    w_din_y      = '{default: {(LANES*W){1'b0}}};
    w_din_ovf    = '{default: {LANES{1'b0}}};
    w_din_tag    = '{default: {TAG_W{1'b0}}};
    w_ld[0]      = bus.start;
    w_din_y[0]   = w_y;
    w_din_ovf[0] = w_ovf;
    w_din_tag[0] = bus.tag_in;
    for (int k = 1; k < STAGES; k++) begin
      w_ld[k]      = r_vld[k-1];
      w_din_y[k]   = r_y[k-1];
      w_din_ovf[k] = r_ovf[k-1];
      w_din_tag[k] = r_tag[k-1];
    end
  end

  // Pipeline stages, busy flag and completion counter; data only moves with its valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= {STAGES{1'b0}};
      r_y    <= '{default: {(LANES*W){1'b0}}};
      r_ovf  <= '{default: {LANES{1'b0}}};
      r_tag  <= '{default: {TAG_W{1'b0}}};
      r_busy <= 1'b0;
      r_cnt  <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_ld[k];
        if (w_ld[k]) begin
          r_y[k]   <= w_din_y[k];
          r_ovf[k] <= w_din_ovf[k];
          r_tag[k] <= w_din_tag[k];
        end
      end
      // Next-cycle OR of stage valids, so busy stays a plain flop
      r_busy <= |w_ld;
      if (w_ld[STAGES-1] && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.y        = r_y[STAGES-1];
  assign bus.ovf      = r_ovf[STAGES-1];
  assign bus.tag_out  = r_tag[STAGES-1];
  assign bus.valid    = r_vld[STAGES-1];
  assign bus.busy     = r_busy;
  assign bus.done_cnt = r_cnt;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Multi-lane, fully pipelined add/subtract unit; parametrised successor to the single-lane, single-cycle adder. It accepts one operation per cycle on a `start` strobe. Each operation applies one of four modes (wrap/saturate × add/subtract) across `LANES` independent `W`-bit lanes. Results appear after a fixed `STAGES`-cycle latency, with per-lane overflow flags, a pass-through tag and a saturating completion counter. The block sits in the datapath cluster as a drop-in for the original adder: `STAGES=1`, `LANES=1`, `op=00` reproduces its behaviour.

## Interface
Parameters:
- `W`, 10, lane width in bits (≥2)
- `LANES`, 2, number of independent lanes (≥1)
- `STAGES`, 2, latency from `start` to `valid` in cycles (≥1)
- `TAG_W`, 4, width of sideband tag (≥1)
- `CNT_W`, 16, width of completion counter (≥1)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  operation strobe; every asserted cycle accepts one op
- `op`  in  2  mode: 00 add-wrap, 01 sub-wrap, 10 add-sat, 11 sub-sat
- `a`  in  LANES*W  operand A; lane i at bits [i*W +: W]
- `b`  in  LANES*W  operand B, same packing
- `tag_in`  in  TAG_W  sideband identifier, carried with the op
- `y`  out  LANES*W  per-lane result, same packing
- `ovf`  out  LANES  per-lane carry (add) / borrow (sub) flag
- `tag_out`  out  TAG_W  `tag_in` of the op presented on `y`
- `valid`  out  1  `y`/`ovf`/`tag_out` hold a new result this cycle
- `busy`  out  1  at least one accepted op not yet retired
- `done_cnt`  out  CNT_W  number of results presented, saturating

## Operation
- Operands are unsigned. Each lane computes in W+1 bits.
  - add: s = a + b; `ovf` = s[W]
  - sub: d = a − b; `ovf` = (a < b)
- Wrap modes: `y` = low W bits of s or d.
- Saturate modes:
  - add with `ovf`=1 gives all-ones (2^W−1)
  - sub with `ovf`=1 gives 0
  - otherwise same as wrap
- `ovf` reports carry/borrow in every mode, including saturate.
- Stage 1 captures `op`, `a`, `b` and `tag_in` and computes the result. Stages 2..STAGES are pure delay registers with a valid bit per stage. The final stage drives the outputs.
- No backpressure. A `start` in every cycle is legal and yields `valid` in every cycle, in order, with no drops.
- `start` is sampled only when `rst_n`=1.
- `y`, `ovf` and `tag_out` update only in cycles where `valid`=1. They hold their last values otherwise, and data registers load only with their stage valid.
- `busy` = OR of all stage valid bits, including the output stage.
- `done_cnt` increments by 1 each cycle `valid`=1 and sticks at 2^CNT_W−1.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces every output to 0 at that edge: `y`, `ovf`, `tag_out`, `valid`, `busy`, `done_cnt`. All stage valid bits clear.
- Reset mid-operation: all in-flight ops are discarded and no `valid` is produced for them. A `start` present on the reset edge is ignored.
- Latency: `start` at edge N gives `valid`=1 in the cycle after edge N+STAGES−1. With `STAGES=1`, `valid` is high in the cycle after the `start` edge.
- `valid` is high for exactly one cycle per accepted op.
- Throughput is 1 op/cycle. `busy` falls in the cycle after the last `valid`.
- The counter at saturation stays at all-ones through further `valid`s. It clears only on reset.
- The first `start` after reset release is accepted on the first edge with `rst_n`=1.

## Test plan
Bench uses W=10, LANES=2, STAGES=3 unless noted.
- **Add-wrap with overflow.** Lane0 a=1000, b=100; lane1 a=5, b=7; op=00. Expect `valid` exactly 3 cycles after start, lane0 `y`=76 `ovf`=1, lane1 `y`=12 `ovf`=0, `tag_out`=`tag_in`.
- **Saturate modes.** Same operands with op=10: lane0 `y`=1023 `ovf`=1, lane1 `y`=12. Then lane0 a=5, b=7 with op=01: `y`=1022 `ovf`=1. Same operands with op=11: `y`=0 `ovf`=1.
- **Back-to-back.** 4 consecutive `start` cycles with tags 1,2,3,4 and mixed ops. Expect 4 consecutive `valid` cycles, tags in order 1..4, each result matching the scoreboard, `done_cnt`=4, `busy` low 1 cycle after the last `valid`.
- **Reset mid-flight.** `start` at edge N, then `rst_n`=0 at edge N+1 for one cycle. Expect no `valid` ever for that op, all outputs 0 from edge N+1, and a new op after release completing normally with `done_cnt`=1.
- **Counter saturation.** CNT_W=4, 20 ops. Expect `done_cnt`=15 after the 15th `valid` and still 15 after the 20th.
- **Legacy equivalence.** LANES=1, STAGES=1, op=00, 10 random ops. Expect `valid` 1 cycle after each `start` and `y`=(a+b) mod 1024.
